// File: rtl/sevseg_scan_driver.sv
// sevseg_scan_driver: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Digits are latched once per frame (tear-free),
// each slot opens with an all-off guard interval, and all outputs are registered.
// Optional feature: define SEVSEG_BLINK_EN to build per-digit blinking
// driven by a frame counter and blink phase.
module sevseg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp,
    input  logic [3:0]  i_blink_mask,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic [3:0]  o_an
);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      shadow_digits_q, shadow_digits_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             slot_wrap, frame_wrap, blank;

`ifdef SEVSEG_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FR_W-1:0]  frame_q, frame_d;
    logic             phase_on_q, phase_on_d;
`else
    // Blink mask is only meaningful in the blink build.
    logic unused_blink_mask;
    assign unused_blink_mask = ^i_blink_mask;
`endif

    // Hex to active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // Next-state: slot/frame counters, frame-boundary shadow capture, output decode.
    always_comb begin
        slot_wrap  = (div_q == DIV_W'(REFRESH_DIV - 1));
        frame_wrap = slot_wrap && (idx_q == 2'd3);
        div_d      = slot_wrap ? '0 : div_q + 1'b1;
        idx_d      = slot_wrap ? idx_q + 2'd1 : idx_q;

        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        if (frame_wrap) begin
            shadow_digits_d = i_digits;
            shadow_dp_d     = i_dp;
        end

        blank = (div_q < DIV_W'(GUARD));
`ifdef SEVSEG_BLINK_EN
        frame_d    = frame_q;
        phase_on_d = phase_on_q;
        if (frame_wrap) begin
            if (frame_q == FR_W'(BLINK_FRAMES - 1)) begin
                frame_d    = '0;
                phase_on_d = ~phase_on_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
        // Blinking digits stay dark for their whole slot in the off phase.
        if (!phase_on_q && i_blink_mask[idx_q])
            blank = 1'b1;
`endif

        if (blank) begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_decode(shadow_digits_q[idx_q*4 +: 4]);
            dp_d  = ~shadow_dp_q[idx_q];
        end

        // Reset drops all progress and forces the display dark.
        if (i_rst) begin
            div_d           = '0;
            idx_d           = '0;
            shadow_digits_d = '0;
            shadow_dp_d     = '0;
            an_d            = 4'hF;
            seg_d           = 7'h7F;
            dp_d            = 1'b1;
`ifdef SEVSEG_BLINK_EN
            frame_d         = '0;
            phase_on_d      = 1'b1;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        div_q           <= div_d;
        idx_q           <= idx_d;
        shadow_digits_q <= shadow_digits_d;
        shadow_dp_q     <= shadow_dp_d;
        an_q            <= an_d;
        seg_q           <= seg_d;
        dp_q            <= dp_d;
`ifdef SEVSEG_BLINK_EN
        frame_q         <= frame_d;
        phase_on_q      <= phase_on_d;
`endif
    end

    assign o_an  = an_q;
    assign o_seg = seg_q;
    assign o_dp  = dp_q;
endmodule
